fix_frame_link: RTL and testbench

- Synthesizable byte-stream link between the outbound port of one FIX engine (fifo_write/message/end) and the inbound port of its peer (new_message/message).
- Replaces the behavioural capture-and-replay loop of the end-to-end system; one instance per direction (initiator->acceptor, acceptor->initiator).
- Stores whole frames and replays a frame only after its end marker has been received; malformed or oversize frames are dropped.

---
 rtl/fix_frame_link.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_fix_frame_link.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_frame_link.sv
// fix_frame_link: store-and-forward byte link between two FIX engines.
// Whole frames are buffered and replayed only after their end marker.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en_i/wr_data_i/wr_end_i  byte stream from sending engine
//   full_o            backpressure to sending engine
//   new_message_o     one-cycle frame-start pulse, id_o frame id
//   message_o/_valid_o/_last_o  replayed bytes, rd_ready_i accept
//   frames_o          committed frames queued
//   drop_cnt_o        saturating dropped-frame counter
module fix_frame_link #(
  parameter int DEPTH  = 512,
  parameter int AW     = 9,
  parameter int FRAMES = 8,
  parameter int GAP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       wr_end_i,
  output logic       full_o,
  output logic       new_message_o,
  output logic [1:0] id_o,
  output logic [7:0] message_o,
  output logic       message_valid_o,
  output logic       message_last_o,
  input  logic       rd_ready_i,
  output logic [3:0] frames_o,
  output logic [7:0] drop_cnt_o
);

  localparam int FW = $clog2(FRAMES);
  localparam int CW = FW + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   NEAR_W   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   ONE_W    = (AW+1)'(1);
  localparam logic [AW:0]   TWO_W    = (AW+1)'(2);
  localparam logic [CW-1:0] FRAMES_W = CW'(FRAMES);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP - 1);

  typedef enum logic [1:0] {
    W_HDR,
    W_BODY,
    W_DROP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_GAP
  } rd_state_e;

  // storage
  logic [7:0]    mem    [DEPTH];
  logic [AW-1:0] dstart [FRAMES];
  logic [AW:0]   dlen   [FRAMES];
  logic [1:0]    did    [FRAMES];

  // write side
  wr_state_e     wst_q, wst_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] start_q, start_d;
  logic [AW:0]   len_q, len_d;
  logic [1:0]    wid_q, wid_d;

  // shared bookkeeping
  logic [AW:0]   used_q, used_d;
  logic [FW-1:0] head_q, head_d;
  logic [FW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic [7:0]    drop_q, drop_d;

  // read side
  rd_state_e     rs_q, rs_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   left_q, left_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          newmsg_q, newmsg_d;
  logic [1:0]    id_q, id_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [7:0]    msg_q;

  logic          push, pop, drop, mem_we;
  logic          rd_xfer, rd_load;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   used_sub;

  always_comb begin
    wst_d    = wst_q;
    wr_ptr_d = wr_ptr_q;
    start_d  = start_q;
    len_d    = len_q;
    wid_d    = wid_q;
    push     = 1'b0;
    drop     = 1'b0;
    mem_we   = 1'b0;
    used_sub = '0;
    unique case (wst_q)
      W_HDR: begin
        if (wr_en_i) begin
          if (wr_end_i) begin
            drop = 1'b1;
          end else begin
            wid_d   = wr_data_i[1:0];
            start_d = wr_ptr_q;
            len_d   = '0;
            wst_d   = W_BODY;
          end
        end
      end
      W_BODY: begin
        if (wr_en_i) begin
          if (used_q == DEPTH_W ||
              (wr_end_i && cnt_q == FRAMES_W)) begin
            // discard this frame's bytes
            wr_ptr_d = start_q;
            used_sub = len_q;
            drop     = 1'b1;
            // an overflow on the end byte closes the frame
            wst_d    = wr_end_i ? W_HDR : W_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            len_d    = len_q + 1'b1;
            if (wr_end_i) begin
              push  = 1'b1;
              wst_d = W_HDR;
            end
          end
        end
      end
      W_DROP: begin
        if (wr_en_i && wr_end_i) wst_d = W_HDR;
      end
      default: wst_d = W_HDR;
    endcase
  end

  always_comb begin
    rs_d     = rs_q;
    rd_ptr_d = rd_ptr_q;
    left_d   = left_q;
    gap_d    = gap_q;
    newmsg_d = 1'b0;
    id_d     = id_q;
    valid_d  = valid_q;
    last_d   = last_q;
    pop      = 1'b0;
    rd_xfer  = 1'b0;
    rd_load  = 1'b0;
    rd_addr  = rd_ptr_q;
    unique case (rs_q)
      R_IDLE: begin
        if (cnt_q != '0) begin
          rs_d     = R_START;
          newmsg_d = 1'b1;
          id_d     = did[head_q];
          rd_ptr_d = dstart[head_q];
          left_d   = dlen[head_q];
        end
      end
      R_START: begin
        rs_d    = R_DATA;
        rd_load = 1'b1;
        valid_d = 1'b1;
        last_d  = (left_q == ONE_W);
      end
      R_DATA: begin
        if (valid_q && rd_ready_i) begin
          rd_xfer = 1'b1;
          if (last_q) begin
            pop     = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
            gap_d   = '0;
            rs_d    = (GAP == 0) ? R_IDLE : R_GAP;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            left_d   = left_q - 1'b1;
            rd_load  = 1'b1;
            rd_addr  = rd_ptr_q + 1'b1;
            last_d   = (left_q == TWO_W);
          end
        end
      end
      R_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_END) rs_d = R_IDLE;
      end
      default: rs_d = R_IDLE;
    endcase
  end

  always_comb begin
    head_d = pop  ? head_q + 1'b1 : head_q;
    tail_d = push ? tail_q + 1'b1 : tail_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    used_d = used_q
           + {{AW{1'b0}}, mem_we}
           - {{AW{1'b0}}, rd_xfer}
           - used_sub;
    full_d = (used_d >= NEAR_W) ||
             (cnt_d == FRAMES_W);
    drop_d = (drop && drop_q != 8'hFF) ?
             drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wst_q    <= W_HDR;
      wr_ptr_q <= '0;
      start_q  <= '0;
      len_q    <= '0;
      wid_q    <= '0;
      used_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      drop_q   <= '0;
      rs_q     <= R_IDLE;
      rd_ptr_q <= '0;
      left_q   <= '0;
      gap_q    <= '0;
      newmsg_q <= 1'b0;
      id_q     <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      msg_q    <= '0;
    end else begin
      wst_q    <= wst_d;
      wr_ptr_q <= wr_ptr_d;
      start_q  <= start_d;
      len_q    <= len_d;
      wid_q    <= wid_d;
      used_q   <= used_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      drop_q   <= drop_d;
      rs_q     <= rs_d;
      rd_ptr_q <= rd_ptr_d;
      left_q   <= left_d;
      gap_q    <= gap_d;
      newmsg_q <= newmsg_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      if (rd_load) msg_q <= mem[rd_addr];
    end
  end

  // storage arrays carry no reset; only valid entries are read
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= wr_data_i;
    if (push) begin
      dstart[tail_q] <= start_q;
      dlen[tail_q]   <= len_q + 1'b1;
      did[tail_q]    <= wid_q;
    end
  end

  assign full_o          = full_q;
  assign new_message_o   = newmsg_q;
  assign id_o            = id_q;
  assign message_o       = msg_q;
  assign message_valid_o = valid_q;
  assign message_last_o  = last_q;
  assign frames_o        = 4'(cnt_q);
  assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_fix_frame_link.sv
// tb_fix_frame_link: directed bench with a byte/id scoreboard
// for the fix_frame_link store-and-forward link.
module tb_fix_frame_link;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic       wr_end_i;
  logic       full_o;
  logic       new_message_o;
  logic [1:0] id_o;
  logic [7:0] message_o;
  logic       message_valid_o;
  logic       message_last_o;
  logic       rd_ready_i;
  logic [3:0] frames_o;
  logic [7:0] drop_cnt_o;

  fix_frame_link dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en_i         (wr_en_i),
    .wr_data_i       (wr_data_i),
    .wr_end_i        (wr_end_i),
    .full_o          (full_o),
    .new_message_o   (new_message_o),
    .id_o            (id_o),
    .message_o       (message_o),
    .message_valid_o (message_valid_o),
    .message_last_o  (message_last_o),
    .rd_ready_i      (rd_ready_i),
    .frames_o        (frames_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] exp_q  [$];
  logic [1:0] exp_id [$];

  int cyc        = 0;
  int n_newmsg   = 0;
  int n_bytes    = 0;
  int max_frames = 0;
  int min_gap    = 1000;
  int last_cyc   = 0;
  bit last_seen  = 0;
  int exp_drop   = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // scoreboard: compare every transferred byte and frame start
  always @(negedge clk) begin
    if (rst) begin
      last_seen = 0;
    end else begin
      if (int'(frames_o) > max_frames) max_frames = frames_o;
      if (new_message_o) begin
        n_newmsg++;
        if (last_seen && (cyc - last_cyc - 1) < min_gap)
          min_gap = cyc - last_cyc - 1;
        check("id_avail", exp_id.size() != 0, 1);
        if (exp_id.size() != 0)
          check("id", id_o, exp_id.pop_front());
      end
      if (message_valid_o && rd_ready_i) begin
        n_bytes++;
        check("byte_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check("byte", {message_last_o, message_o},
                exp_q.pop_front());
        if (message_last_o) begin
          last_seen = 1;
          last_cyc  = cyc;
        end
      end
    end
  end

  task automatic put(input logic [7:0] d, input logic e);
    wr_en_i   = 1'b1;
    wr_data_i = d;
    wr_end_i  = e;
    @(posedge clk); #1;
    wr_en_i  = 1'b0;
    wr_end_i = 1'b0;
  endtask

  task automatic send(input logic [1:0] id, input int n,
                      input logic [7:0] base, input int step,
                      input bit keep);
    logic [7:0] d;
    logic       e;
    if (keep && n > 0) exp_id.push_back(id);
    put({6'h15, id}, n == 0);
    for (int i = 0; i < n; i++) begin
      d = base + 8'(step * i);
      e = (i == n - 1);
      if (keep) exp_q.push_back({e, d});
      put(d, e);
    end
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_ids"}, exp_id.size(), 0);
    check({tag, "_frames"}, frames_o, 0);
    check({tag, "_drop"}, drop_cnt_o, exp_drop);
  endtask

  initial begin
    logic [7:0] m;
    logic       v;
    logic       l;
    logic [7:0] d;
    rst        = 1'b1;
    wr_en_i    = 1'b0;
    wr_data_i  = '0;
    wr_end_i   = 1'b0;
    rd_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_full", full_o, 0);
    check("rst_newmsg", new_message_o, 0);
    check("rst_id", id_o, 0);
    check("rst_msg", message_o, 0);
    check("rst_valid", message_valid_o, 0);
    check("rst_last", message_last_o, 0);
    check("rst_frames", frames_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    rst        = 1'b0;
    rd_ready_i = 1'b1;
    @(posedge clk); #1;

    // single 38-byte frame
    n_newmsg = 0;
    n_bytes  = 0;
    send(2'b01, 38, 8'h38, 5, 1);
    drain("t1");
    check("t1_pulses", n_newmsg, 1);
    check("t1_bytes", n_bytes, 38);

    // back-to-back 5 and 3 byte frames
    n_newmsg   = 0;
    n_bytes    = 0;
    max_frames = 0;
    min_gap    = 1000;
    send(2'b10, 5, 8'hA0, 1, 1);
    send(2'b11, 3, 8'hC0, 3, 1);
    drain("t2");
    check("t2_pulses", n_newmsg, 2);
    check("t2_bytes", n_bytes, 8);
    check("t2_peak", max_frames, 2);
    check("t2_gap", min_gap >= 2, 1);

    // 511-byte frame fills RAM to DEPTH-1, stalled reader
    rd_ready_i = 1'b0;
    n_bytes    = 0;
    exp_id.push_back(2'b00);
    put(8'h54, 1'b0);
    for (int i = 0; i < 510; i++) begin
      d = 8'(i * 3 + 1);
      exp_q.push_back({1'b0, d});
      put(d, 1'b0);
    end
    check("t3_not_full", full_o, 0);
    d = 8'(510 * 3 + 1);
    exp_q.push_back({1'b1, d});
    put(d, 1'b1);
    check("t3_full", full_o, 1);
    check("t3_frames", frames_o, 1);
    repeat (4) @(posedge clk);
    #1;
    check("t3_valid_wait", message_valid_o, 1);
    rd_ready_i = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rd_ready_i = 1'b0;
    m = message_o;
    v = message_valid_o;
    l = message_last_o;
    repeat (10) @(posedge clk);
    #1;
    check("t3_hold_msg", message_o, m);
    check("t3_hold_valid", message_valid_o, v);
    check("t3_hold_last", message_last_o, l);
    check("t3_hold_v1", v, 1);
    rd_ready_i = 1'b1;
    drain("t3");
    check("t3_bytes", n_bytes, 511);

    // oversize frame is dropped, next frame replays
    n_newmsg = 0;
    n_bytes  = 0;
    send(2'b10, 600, 8'h11, 1, 0);
    exp_drop++;
    repeat (6) @(posedge clk);
    #1;
    check("t4_drop", drop_cnt_o, exp_drop);
    check("t4_frames", frames_o, 0);
    check("t4_no_msg", n_newmsg, 0);
    send(2'b01, 4, 8'hE0, 2, 1);
    drain("t4");
    check("t4_pulses", n_newmsg, 1);
    check("t4_bytes", n_bytes, 4);

    // header-only frame
    n_newmsg = 0;
    send(2'b11, 0, 8'h00, 0, 0);
    exp_drop++;
    repeat (6) @(posedge clk);
    #1;
    check("t5_drop", drop_cnt_o, exp_drop);
    check("t5_no_msg", n_newmsg, 0);

    // reset in the middle of a frame
    put(8'h56, 1'b0);
    for (int i = 0; i < 20; i++) put(8'(i + 8'h70), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_full", full_o, 0);
    check("t6_newmsg", new_message_o, 0);
    check("t6_id", id_o, 0);
    check("t6_msg", message_o, 0);
    check("t6_valid", message_valid_o, 0);
    check("t6_last", message_last_o, 0);
    check("t6_frames", frames_o, 0);
    check("t6_drop", drop_cnt_o, 0);
    exp_drop = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_newmsg = 0;
    n_bytes  = 0;
    send(2'b10, 12, 8'h30, 7, 1);
    drain("t6");
    check("t6_pulses", n_newmsg, 1);
    check("t6_bytes", n_bytes, 12);

    // 600 bytes total forces the write pointer across 511->0
    n_bytes = 0;
    send(2'b00, 200, 8'h05, 11, 1);
    send(2'b01, 200, 8'h9A, 13, 1);
    send(2'b11, 200, 8'h42, 5, 1);
    drain("t7");
    check("t7_bytes", n_bytes, 600);
    check("t7_full", full_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
